// File: rtl/popcount24_pkg.sv
// Shared definitions for the popcount24 family: widths, the pattern
// generator FSM state encoding, the LFSR tap constant and an exact
// reference popcount.
package popcount24_pkg;

    localparam int N_IN  = 24;
    localparam int CNT_W = 5;

    // Galois feedback mask for the 16-bit maximal-length LFSR.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    // SET: start from zeros and turn bits on; CLEAR: start from ones and
    // turn bits off. Whichever needs at most 12 toggles is chosen.
    typedef enum logic {
        MODE_SET   = 1'b0,
        MODE_CLEAR = 1'b1
    } mode_t;

    function automatic logic [CNT_W-1:0] popcount24_exact(input logic [N_IN-1:0] v);
        logic [CNT_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < N_IN; i++) begin
            acc = acc + CNT_W'(v[i]);
        end
        return acc;
    endfunction

endpackage

// File: rtl/popcount24_pattern_gen_if.sv
// Request/response bundle of the popcount24 pattern generator.
//   count_in    : requested number of ones (25..31 clamp to 24)
//   in_valid    : request valid           in_ready  : generator idle
//   pattern_out : generated 24-bit vector out_valid : pattern held
//   out_ready   : consumer accepts        sat_out   : request was clamped
// Handshake: both channels are strict valid/ready. A transfer happens on a
// rising edge where valid & ready are both high; a valid source keeps its
// payload stable until that edge, and ready never depends on valid.
// master = requester/consumer side, slave = generator side.
interface popcount24_pattern_gen_if;
    import popcount24_pkg::*;

    logic [CNT_W-1:0] count_in;
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  pattern_out;
    logic             out_valid;
    logic             out_ready;
    logic             sat_out;

    modport master (
        output count_in, in_valid, out_ready,
        input  in_ready, pattern_out, out_valid, sat_out
    );

    modport slave (
        input  count_in, in_valid, out_ready,
        output in_ready, pattern_out, out_valid, sat_out
    );

endinterface

// File: rtl/lfsr16_galois.sv
// 16-bit right-shifting Galois LFSR that advances on every clock.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, loads SEED (must be nonzero)
//   state : current LFSR contents
module lfsr16_galois
    import popcount24_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/popcount24_pattern_gen.sv
// Pattern generator: emits a 24-bit vector with exactly min(count_in, 24)
// ones, placed pseudo-randomly by an LFSR, with a deterministic
// lowest-index fallback after MAX_TRIES random attempts.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : request/response channel (slave side)
//   dbg_state : current FSM state
module popcount24_pattern_gen
    import popcount24_pkg::*;
#(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_TRIES = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    popcount24_pattern_gen_if.slave   bus,
    output state_t                    dbg_state
);

    state_t            state;
    mode_t             mode;
    logic [N_IN-1:0]   work;
    logic [N_IN-1:0]   pattern_q;
    logic [3:0]        remaining;
    logic [6:0]        tries;
    logic              sat_q;
    logic              out_valid_q;
    logic [15:0]       lfsr;

    lfsr16_galois #(.SEED(SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr)
    );

    // Only the low five LFSR bits pick a candidate index.
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^lfsr[15:5];

    logic [CNT_W-1:0] cnt_sat;
    logic             req_sat;
    assign req_sat = (bus.count_in > 5'd24);
    assign cnt_sat = req_sat ? 5'd24 : bus.count_in;

    // Bits that still have to be toggled to reach the target state.
    logic [N_IN-1:0] pending;
    logic [31:0]     pending_ext;
    assign pending     = (mode == MODE_SET) ? ~work : work;
    assign pending_ext = {8'h00, pending};

    logic [4:0] rand_k;
    logic       rand_ok;
    assign rand_k  = lfsr[4:0];
    assign rand_ok = (rand_k < 5'd24) && pending_ext[rand_k];

    // Lowest-index pending bit for the fallback path.
    logic [4:0] fb_idx;
    always_comb begin
        fb_idx = '0;
        for (int i = N_IN - 1; i >= 0; i--) begin
            if (pending[i]) fb_idx = 5'(i);
        end
    end

    logic            use_fallback;
    logic            pick_ok;
    logic [4:0]      pick_idx;
    logic [N_IN-1:0] toggle;
    logic [N_IN-1:0] work_next;

    assign use_fallback = (int'(tries) >= MAX_TRIES);

    always_comb begin
        pick_ok  = rand_ok;
        pick_idx = rand_k;
        if (use_fallback) begin
            pick_ok  = |pending;
            pick_idx = fb_idx;
        end
    end

    assign toggle    = pick_ok ? (24'd1 << pick_idx) : '0;
    assign work_next = work ^ toggle;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mode        <= MODE_SET;
            work        <= '0;
            pattern_q   <= '0;
            remaining   <= '0;
            tries       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        sat_q <= req_sat;
                        tries <= '0;
                        if (cnt_sat <= 5'd12) begin
                            mode      <= MODE_SET;
                            work      <= '0;
                            remaining <= cnt_sat[3:0];
                        end else begin
                            mode      <= MODE_CLEAR;
                            work      <= '1;
                            remaining <= 4'(5'd24 - cnt_sat);
                        end
                        // 0 and 24 need no toggles: present immediately.
                        if (cnt_sat == 5'd0 || cnt_sat == 5'd24) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            pattern_q   <= (cnt_sat == 5'd0) ? '0 : '1;
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (tries != 7'h7F) tries <= tries + 7'd1;
                    if (pick_ok) begin
                        work      <= work_next;
                        remaining <= remaining - 4'd1;
                        // The output register is loaded only with the
                        // finished vector, so a partial one never shows.
                        if (remaining == 4'd1) begin
                            state       <= DONE;
                            out_valid_q <= 1'b1;
                            pattern_q   <= work_next;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Gated by rst so the generator never looks ready in a reset cycle.
    assign bus.in_ready    = (state == IDLE) && !rst;
    assign bus.pattern_out = pattern_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.sat_out     = sat_q;
    assign dbg_state       = state;

endmodule

// File: doc/popcount24_pattern_gen.md
# popcount24_pattern_gen

Sequential stimulus source for the 24-input popcount family. It takes a target count (0..24) and emits a 24-bit activation vector holding exactly that many ones, scattered pseudo-randomly by an internal LFSR. It sits upstream of the popcount24 approximate circuits, both in the characterisation harness (MAE/WCE/EP measurement) and as the input stage of the on-sensor ternary-neuron test array. It drives the popcount; the popcount is its receiver.

## Interface
- `SEED`, default 16'hACE1: LFSR reset value; must be nonzero.
- `MAX_TRIES`, default 64: random placement attempts before the deterministic fallback.
- `clk`  in  1: single clock, all logic rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `count_in`  in  5: requested ones count; values 25..31 saturate to 24.
- `in_valid`  in  1: request valid.
- `in_ready`  out  1: high only in IDLE.
- `pattern_out`  out  24: generated vector, registered.
- `out_valid`  out  1: pattern complete and held.
- `out_ready`  in  1: consumer accepts the pattern.
- `sat_out`  out  1: the request was clamped (`count_in` > 24); valid with `out_valid`.

## Operation
- States: IDLE, FILL, DONE.
- IDLE: `in_ready`=1. On `in_valid`:
  - latch `c` = min(`count_in`, 24) and `sat`.
  - If `c` ≤ 12: clear the working vector, set mode SET, `remaining` = `c`.
  - Otherwise: set the working vector to all ones, mode CLEAR, `remaining` = 24−`c`.
  - Set `tries` = 0. Go to DONE if `remaining` = 0, else FILL.
- FILL, each cycle:
  - Candidate index `k` = `lfsr[4:0]`.
  - The candidate is accepted if `k` < 24 and bit `k` is not yet in the target state (SET: bit `k` = 0; CLEAR: bit `k` = 1).
  - Accept: toggle bit `k` and decrement `remaining`.
  - `tries` increments on every FILL cycle. Once `tries` = `MAX_TRIES`, switch to fallback: each cycle toggle the lowest-index bit not yet in the target state.
  - When `remaining` reaches 0, go to DONE on the next edge.
- DONE: `out_valid`=1 and `pattern_out`/`sat_out` are stable. On `out_ready`, go to IDLE.
- LFSR:
  - 16-bit Galois, taps 16'hB400, shifted once per clock in every state.
  - Pattern sequence is therefore a function of `SEED` and request timing.
- Invariant: popcount(`pattern_out`) = min(`count_in`, 24) whenever `out_valid`=1.
- Widths:
  - `remaining` is 4 bits (max 12).
  - `tries` is 7 bits and saturates.
  - `count_in` compare is unsigned, 5 bits.

## Timing
- Reset values: `in_ready`=0 during the reset cycle, then 1 from the first post-reset cycle; `out_valid`=0, `pattern_out`=0, `sat_out`=0, state IDLE, `lfsr`=`SEED`.
- Latency, accept edge to `out_valid`:
  - `c` ∈ {0, 24}: 1 cycle.
  - Otherwise: `remaining` accepted FILL cycles + 1. Worst case is `MAX_TRIES` + 12 + 1.
- Handshakes:
  - Input: a transfer occurs when `in_valid` & `in_ready`.
  - Output: a transfer occurs when `out_valid` & `out_ready`.
  - No input is accepted in the cycle the output transfers; IDLE is re-entered the next cycle (max throughput one pattern per latency+2).
- Backpressure: `out_valid` stays high and `pattern_out` is unchanged while `out_ready`=0, indefinitely.
- `in_valid` outside IDLE is ignored; no queueing.
- `rst` asserted in any state (including mid-FILL) aborts the operation: next cycle all outputs take their reset values; a partial pattern is never presented.

## Structure
- Shared package `popcount24_pkg`:
  - `N_IN`=24, `CNT_W`=5.
  - state enum {IDLE, FILL, DONE}.
  - LFSR tap constant.
  - function `popcount24_exact` (used by the bench and the characterisation harness).
- Sub-module `lfsr16_galois`: clk, rst, seed parameter, 16-bit state output, advances every cycle.
- Top-level instance: FSM, working register and priority-encoder fallback.

## Test plan
- `count_in`=0 -> `out_valid` 1 cycle after accept, `pattern_out`=24'h000000, `sat_out`=0.
- `count_in`=24 -> `pattern_out`=24'hFFFFFF after 1 cycle; `count_in`=31 -> 24'hFFFFFF with `sat_out`=1.
- Sweep `count_in` 0..24, 50 requests each, random `out_ready` -> popcount(`pattern_out`) equals the request every time, and `pattern_out` is stable while `out_valid` & !`out_ready`.
- `MAX_TRIES`=0, `count_in`=5 -> `pattern_out`=24'h00001F; `count_in`=20 -> 24'hFFFFF0 (clears bits 0..3).
- `rst` pulse during FILL with `count_in`=10 -> next cycle `out_valid`=0, `pattern_out`=0, `in_ready`=1; the next request completes correctly.
- `in_valid` held high in DONE with `out_ready`=0 for 20 cycles -> no new request is accepted and the pattern is unchanged.
